// File: rtl/ga_phase_controller.sv
// ga_phase_controller: generation sequencer driving the shared state_controller bus of the GA datapath.
// Define GA_STALL_RESTART_EN to re-initialise the population after stallLimit generations without improvement.
module ga_phase_controller #(
  parameter int primaryInputCount = 8,
  parameter logic [15:0] maxGenerations = 16'd1000,
  parameter logic [19:0] phaseTimeout = 20'd65535,
  parameter logic [7:0] stallLimit = 8'd50
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic start,
  input  logic initDone,
  input  logic evalDone,
  input  logic sortDone,
  input  logic [3:0] state_mutationFSM,
  input  logic [primaryInputCount+1:0] bestFitness,
  input  logic [primaryInputCount+1:0] targetFitness,
  output logic [2:0] state_controller,
  output logic phaseStart,
  output logic [15:0] generation,
  output logic [primaryInputCount+1:0] bestFitnessReg,
  output logic finished,
  output logic timeoutErr
);
  typedef enum logic [2:0] {
    IDLE = 3'b000, INIT = 3'b001, EVAL = 3'b010, MUTATE = 3'b011,
    SORT = 3'b100, CHECK = 3'b101, DONE = 3'b110, UNUSED = 3'b111
  } phase_t;
  phase_t state, nextState;
  logic [19:0] watchdog;
  logic working, timedOut, improved, terminate, launch, restart;
`ifdef GA_STALL_RESTART_EN
  logic [7:0] stallCount, stallNext;
`else
  logic unusedStallLimit;
  assign unusedStallLimit = ^stallLimit;
`endif
  assign state_controller = state;
  always_comb begin
    working = state inside {INIT, EVAL, SORT, MUTATE};
    timedOut = working && watchdog == phaseTimeout - 20'd1;
    improved = bestFitness > bestFitnessReg;
    terminate = bestFitness >= targetFitness || generation == maxGenerations - 16'd1;
    launch = (state == IDLE || state == DONE) && start;
`ifdef GA_STALL_RESTART_EN
    stallNext = improved ? 8'd0 : stallCount + 8'd1;
    restart = !terminate && stallNext >= stallLimit;
`else
    restart = 1'b0;
`endif
    nextState = state;
    if (timedOut) nextState = DONE;
    else case (state)
      IDLE, DONE: if (start) nextState = INIT;
      INIT: if (initDone) nextState = EVAL;
      EVAL: if (evalDone) nextState = SORT;
      SORT: if (sortDone) nextState = CHECK;
      MUTATE: if (state_mutationFSM == 4'b1001) nextState = EVAL;
      CHECK: nextState = terminate ? DONE : restart ? INIT : MUTATE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phaseStart <= 1'b0;
      generation <= '0;
      bestFitnessReg <= '0;
      finished <= 1'b0;
      timeoutErr <= 1'b0;
      watchdog <= '0;
`ifdef GA_STALL_RESTART_EN
      stallCount <= '0;
`endif
    end else begin
      state <= nextState;
      phaseStart <= nextState != state && nextState inside {INIT, EVAL, SORT, MUTATE};
      finished <= nextState == DONE;
      watchdog <= nextState != state ? 20'd0 : working ? watchdog + 20'd1 : watchdog;
      if (timedOut) timeoutErr <= 1'b1;
      if (launch) begin
        generation <= '0;
        bestFitnessReg <= '0;
        timeoutErr <= 1'b0;
`ifdef GA_STALL_RESTART_EN
        stallCount <= '0;
`endif
      end else if (state == CHECK) begin
        if (improved) bestFitnessReg <= bestFitness;
        if (!terminate && !restart && generation != 16'hFFFF) generation <= generation + 16'd1;
`ifdef GA_STALL_RESTART_EN
        stallCount <= restart ? 8'd0 : stallNext;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ga_phase_controller.sv
// tb_ga_phase_controller: table vectors, directed corner sequences and randomized run against a phase-level model.
module tb_ga_phase_controller;
  localparam int MAXG = 5;
  localparam int TO = 100;
  localparam int LIM = 2;
`ifdef GA_STALL_RESTART_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, initDone = 1'b0, evalDone = 1'b0, sortDone = 1'b0;
  logic [3:0] mut = 4'd0;
  logic [9:0] bf = 10'd0, tgt = 10'd0;
  logic [2:0] state_controller;
  logic phaseStart, finished, timeoutErr;
  logic [15:0] generation;
  logic [9:0] bestFitnessReg;
  int checks = 0, errors = 0;
  int mPh, mAge, mGen, mBest, mStall;
  bit mPs, mFin, mTerr;
  int nChecks;
  typedef struct { int s, i, e, so, m, f, st, ps, gen, best, fin; } vec_t;
  vec_t tbl[17];

  ga_phase_controller #(.primaryInputCount(8), .maxGenerations(16'(MAXG)), .phaseTimeout(20'(TO)), .stallLimit(8'(LIM))) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .initDone(initDone), .evalDone(evalDone),
    .sortDone(sortDone), .state_mutationFSM(mut), .bestFitness(bf), .targetFitness(tgt),
    .state_controller(state_controller), .phaseStart(phaseStart), .generation(generation),
    .bestFitnessReg(bestFitnessReg), .finished(finished), .timeoutErr(timeoutErr)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic modelReset();
    mPh = 0; mAge = 0; mGen = 0; mBest = 0; mStall = 0; mPs = 0; mFin = 0; mTerr = 0;
  endtask

  // One clock of the phase sequencer, computed from the current inputs.
  task automatic modelStep();
    int nxt = mPh;
    bit imp;
    if (mPh inside {1, 2, 3, 4} && mAge == TO - 1) begin
      nxt = 6;
      mTerr = 1;
    end else case (mPh)
      0, 6: if (start) begin nxt = 1; mGen = 0; mBest = 0; mTerr = 0; mStall = 0; end
      1: if (initDone) nxt = 2;
      2: if (evalDone) nxt = 4;
      4: if (sortDone) nxt = 5;
      3: if (mut == 4'd9) nxt = 2;
      5: begin
        imp = int'(bf) > mBest;
        if (int'(bf) >= int'(tgt) || mGen == MAXG - 1) nxt = 6;
        else if (STALL && (imp ? 0 : mStall + 1) >= LIM) nxt = 1;
        else begin
          nxt = 3;
          if (mGen < 65535) mGen++;
        end
        mStall = (imp || nxt == 1) ? 0 : mStall + 1;
        if (imp) mBest = int'(bf);
      end
      default: nxt = 0;
    endcase
    mAge = (nxt != mPh) ? 0 : mAge + 1;
    mPs = nxt != mPh && nxt inside {1, 2, 3, 4};
    mFin = nxt == 6;
    mPh = nxt;
  endtask

  task automatic compareAll();
    chk("state", int'(state_controller), mPh);
    chk("phaseStart", int'(phaseStart), int'(mPs));
    chk("generation", int'(generation), mGen);
    chk("bestFitnessReg", int'(bestFitnessReg), mBest);
    chk("finished", int'(finished), int'(mFin));
    chk("timeoutErr", int'(timeoutErr), int'(mTerr));
  endtask

  task automatic cyc();
    modelStep();
    @(negedge CLOCK_50);
    compareAll();
    if (mPh == 5) nChecks++;
  endtask

  function automatic vec_t v(int s, int i, int e, int so, int m, int f, int st, int ps, int gen, int best, int fin);
    vec_t r;
    r.s = s; r.i = i; r.e = e; r.so = so; r.m = m; r.f = f;
    r.st = st; r.ps = ps; r.gen = gen; r.best = best; r.fin = fin;
    return r;
  endfunction

  task automatic allDone(bit x);
    initDone = x; evalDone = x; sortDone = x; mut = x ? 4'd9 : 4'd0;
  endtask

  task automatic runToDone(string n);
    for (int k = 0; k < 100 && mPh != 6; k++) cyc();
    chk(n, int'(finished), 1);
  endtask

  initial begin
    tbl[0]  = v(1, 0, 0, 0, 0, 0,   1, 1, 0, 0,   0);
    tbl[1]  = v(0, 1, 0, 0, 0, 0,   2, 1, 0, 0,   0);
    tbl[2]  = v(0, 0, 0, 1, 0, 0,   2, 0, 0, 0,   0);
    tbl[3]  = v(0, 0, 1, 0, 0, 0,   4, 1, 0, 0,   0);
    tbl[4]  = v(0, 0, 0, 1, 0, 0,   5, 0, 0, 0,   0);
    tbl[5]  = v(0, 0, 0, 0, 0, 100, 3, 1, 1, 100, 0);
    tbl[6]  = v(0, 0, 0, 0, 8, 100, 3, 0, 1, 100, 0);
    tbl[7]  = v(0, 0, 0, 0, 9, 0,   2, 1, 1, 100, 0);
    tbl[8]  = v(0, 0, 1, 0, 0, 0,   4, 1, 1, 100, 0);
    tbl[9]  = v(0, 0, 0, 1, 0, 0,   5, 0, 1, 100, 0);
    tbl[10] = v(0, 0, 0, 0, 0, 200, 3, 1, 2, 200, 0);
    tbl[11] = v(0, 0, 0, 0, 9, 0,   2, 1, 2, 200, 0);
    tbl[12] = v(0, 0, 1, 0, 0, 0,   4, 1, 2, 200, 0);
    tbl[13] = v(0, 0, 0, 1, 0, 0,   5, 0, 2, 200, 0);
    tbl[14] = v(0, 0, 0, 0, 0, 256, 6, 0, 2, 256, 1);
    tbl[15] = v(0, 0, 0, 0, 0, 0,   6, 0, 2, 256, 1);
    tbl[16] = v(0, 0, 0, 0, 9, 0,   6, 0, 2, 256, 1);
    nChecks = 0;
    #1 reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    modelReset();
    compareAll();

    tgt = 10'd256;
    foreach (tbl[r]) begin
      start = tbl[r].s[0]; initDone = tbl[r].i[0]; evalDone = tbl[r].e[0];
      sortDone = tbl[r].so[0]; mut = 4'(tbl[r].m); bf = 10'(tbl[r].f);
      cyc();
      chk($sformatf("vec%0d.state", r), int'(state_controller), tbl[r].st);
      chk($sformatf("vec%0d.phaseStart", r), int'(phaseStart), tbl[r].ps);
      chk($sformatf("vec%0d.generation", r), int'(generation), tbl[r].gen);
      chk($sformatf("vec%0d.best", r), int'(bestFitnessReg), tbl[r].best);
      chk($sformatf("vec%0d.finished", r), int'(finished), tbl[r].fin);
    end
    mut = 4'd0;

    start = 1'b1; cyc(); start = 1'b0;
    initDone = 1'b1; cyc(); initDone = 1'b0;
    for (int k = 1; k < TO; k++) cyc();
    chk("wd.stillEval", int'(state_controller), 2);
    cyc();
    chk("wd.state", int'(state_controller), 6);
    chk("wd.timeoutErr", int'(timeoutErr), 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("wd.restart", int'(state_controller), 1);
    chk("wd.cleared", int'(timeoutErr), 0);

    initDone = 1'b1; cyc(); initDone = 1'b0;
    #2 reset = 1'b1;
    #1 modelReset();
    compareAll();
    @(negedge CLOCK_50);
    reset = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("rst.start", int'(state_controller), 1);
    chk("rst.pulse", int'(phaseStart), 1);

    initDone = 1'b1; evalDone = 1'b1; cyc(); cyc();
    chk("stale.sort", int'(state_controller), 4);
    chk("stale.pulse", int'(phaseStart), 1);
    allDone(1'b0);

    allDone(1'b1); bf = 10'd5; tgt = 10'd1023;
    runToDone("mg.drain");
    start = 1'b1; cyc(); start = 1'b0;
    nChecks = 0;
    runToDone("mg.done");
    chk("mg.generation", int'(generation), MAXG - 1);
    chk("mg.timeoutErr", int'(timeoutErr), 0);
    chk("mg.checks", nChecks, STALL ? 7 : 5);

    start = 1'b1; cyc(); start = 1'b0;
    nChecks = 0;
    for (int k = 0; k < 40 && nChecks < 3; k++) cyc();
    cyc();
    chk("stall.next", int'(state_controller), STALL ? 1 : 3);
    chk("stall.generation", int'(generation), STALL ? 2 : 3);
    chk("stall.pulse", int'(phaseStart), 1);

    for (int k = 0; k < 3000; k++) begin
      start = $urandom_range(0, 3) == 0;
      initDone = $urandom_range(0, 3) == 0;
      evalDone = $urandom_range(0, 3) == 0;
      sortDone = $urandom_range(0, 3) == 0;
      mut = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
      bf = 10'($urandom);
      tgt = 10'($urandom_range(700, 1023));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
